// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch queue: FSM states, word size and queue entry layout.
package fetch_pkg;

  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FLUSH
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of prefetched {pc, inst} entries with wrapping pointers and an occupancy count.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  input  logic          clear,
  output logic          full,
  output logic          empty,
  output entry_t        head,
  output logic [CW-1:0] count
);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; count gates validity, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: one outstanding memory request, redirect flush, registered head outputs.
// Optional same-cycle ack-to-consumer bypass enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t        state, state_next;
  logic [31:0]   fetch_pc, fetch_pc_next;
  logic [31:0]   req_addr, req_addr_next;
  logic          push, pop, full, empty, bypass;
  logic [CW-1:0] count, count_after;
  entry_t        head, push_data;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .clear     (redirect),
    .full      (full),
    .empty     (empty),
    .head      (head),
    .count     (count)
  );

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = empty && !redirect && (state == WAIT) && mem_ack;
`else
  assign bypass = 1'b0;
`endif

  assign mem_req     = (state == WAIT) || (state == FLUSH);
  assign mem_addr    = req_addr;
  assign push_data   = '{pc: req_addr, inst: mem_rdata};
  assign pop         = !empty && inst_ready && !redirect;
  assign push        = (state == WAIT) && mem_ack && !redirect && !(bypass && inst_ready);
  assign count_after = count + CW'(push) - CW'(pop);

  always_comb begin
    inst_valid = !empty;
    inst       = empty ? 32'h0 : head.inst;
    inst_pc    = empty ? 32'h0 : head.pc;
    if (bypass) begin
      inst_valid = 1'b1;
      inst       = mem_rdata;
      inst_pc    = req_addr;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    req_addr_next = req_addr;
    unique case (state)
      IDLE: begin
        if (redirect) begin
          fetch_pc_next = redirect_pc;
        end else if (!full) begin
          state_next    = WAIT;
          req_addr_next = fetch_pc;
        end
      end
      WAIT: begin
        if (redirect) begin
          fetch_pc_next = redirect_pc;
          state_next    = mem_ack ? IDLE : FLUSH;
        end else if (mem_ack) begin
          fetch_pc_next = fetch_pc + 32'(WORD_BYTES);
          // Reissue immediately when the slot for the next word is already free.
          if (count_after < CW'(DEPTH)) req_addr_next = fetch_pc + 32'(WORD_BYTES);
          else                          state_next    = IDLE;
        end
      end
      FLUSH: begin
        if (redirect) fetch_pc_next = redirect_pc;
        if (mem_ack)  state_next    = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= 32'h0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      req_addr <= req_addr_next;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (default build, DEPTH=4, RESET_PC=0).
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  int   errors = 0;
  int   checks = 0;
  int   acks   = 0;
  logic auto_ack = 1'b0;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory answers in the same cycle a request is visible; data is the inverted address.
  task automatic cycle();
    if (auto_ack) begin
      mem_ack   = mem_req;
      mem_rdata = ~mem_addr;
    end
    if (mem_ack) acks++;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench at a falling edge with reset just released and the DUT in IDLE.
  task automatic do_reset();
    reset       = 1'b0;
    mem_ack     = 1'b0;
    mem_rdata   = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    inst_ready  = 1'b0;
    auto_ack    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_inst_valid", inst_valid, 0);
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, 0);
    acks  = 0;
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        seen;
    logic [31:0] first_addr;

    // Free run: one instruction per cycle, pc 0,4,8,12.
    do_reset();
    inst_ready = 1'b1;
    auto_ack   = 1'b1;
    check("run_req_t0", mem_req, 0);
    cycle();
    check("run_req_t1", mem_req, 1);
    check("run_addr_t1", mem_addr, 32'h0);
    cycle();
    for (int k = 0; k < 4; k++) begin
      check("run_valid", inst_valid, 1);
      check("run_pc", inst_pc, 32'(4 * k));
      check("run_inst", inst, ~32'(4 * k));
      check("run_addr", mem_addr, 32'(4 * k + 4));
      cycle();
    end

    // Backpressure: exactly DEPTH acks, then drain and resume at 16.
    do_reset();
    auto_ack = 1'b1;
    repeat (12) cycle();
    check("bp_acks", 32'(acks), 4);
    check("bp_req_off", mem_req, 0);
    check("bp_valid", inst_valid, 1);
    check("bp_pc_hold", inst_pc, 32'h0);
    inst_ready = 1'b1;
    seen       = 1'b0;
    first_addr = 32'h0;
    for (int k = 0; k < 4; k++) begin
      check("bp_drain_pc", inst_pc, 32'(4 * k));
      if (mem_req && !seen) begin
        seen       = 1'b1;
        first_addr = mem_addr;
      end
      cycle();
    end
    check("bp_resume_seen", seen, 1);
    check("bp_resume_addr", first_addr, 32'h10);

    // Redirect while WAIT, ack arrives three cycles later and is dropped.
    do_reset();
    inst_ready = 1'b1;
    cycle();
    check("fl_req", mem_req, 1);
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    cycle();
    redirect = 1'b0;
    check("fl_req_held", mem_req, 1);
    check("fl_addr_held", mem_addr, 32'h0);
    cycle();
    cycle();
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    cycle();
    mem_ack = 1'b0;
    check("fl_dropped", inst_valid, 0);
    cycle();
    check("fl_new_req", mem_req, 1);
    check("fl_new_addr", mem_addr, 32'h100);
    auto_ack = 1'b1;
    cycle();
    check("fl_first_pc", inst_pc, 32'h100);
    check("fl_first_inst", inst, ~32'h100);

    // Redirect and ack in the same cycle: no push, next request at 0x40.
    do_reset();
    inst_ready = 1'b1;
    cycle();
    mem_ack     = 1'b1;
    mem_rdata   = 32'h12345678;
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    cycle();
    mem_ack  = 1'b0;
    redirect = 1'b0;
    check("ra_no_push", inst_valid, 0);
    check("ra_idle", mem_req, 0);
    cycle();
    check("ra_req", mem_req, 1);
    check("ra_addr", mem_addr, 32'h40);

    // Reset mid-WAIT, then a late ack in IDLE is ignored.
    do_reset();
    cycle();
    check("mr_wait", mem_req, 1);
    reset = 1'b0;
    #1;
    check("mr_async_req", mem_req, 0);
    @(negedge clk);
    reset     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'h55555555;
    cycle();
    mem_ack = 1'b0;
    check("mr_ignored", inst_valid, 0);
    check("mr_restart_req", mem_req, 1);
    check("mr_restart_addr", mem_addr, 32'h0);
    inst_ready = 1'b1;
    auto_ack   = 1'b1;
    cycle();
    check("mr_first_inst", inst, ~32'h0);

    // Address wrap from 0xFFFFFFFC to 0.
    do_reset();
    inst_ready = 1'b1;
    cycle();
    mem_ack     = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFFFFFC;
    cycle();
    mem_ack  = 1'b0;
    redirect = 1'b0;
    cycle();
    check("wr_addr_top", mem_addr, 32'hFFFFFFFC);
    auto_ack = 1'b1;
    cycle();
    check("wr_addr_wrap", mem_addr, 32'h0);
    check("wr_pc_top", inst_pc, 32'hFFFFFFFC);

    // Redirect with a full queue empties it in the next cycle.
    do_reset();
    auto_ack = 1'b1;
    repeat (8) cycle();
    check("rq_full_valid", inst_valid, 1);
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    cycle();
    redirect = 1'b0;
    check("rq_cleared", inst_valid, 0);
    check("rq_inst_zero", inst, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
